// File: rtl/sync_receive_pkg.sv
// Shared state encoding and helpers for the board-to-board sync blocks.
// Used by both the sync pulse generator and the receive side.
package sync_receive_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DELAY = 3'd3,
        ST_DONE  = 3'd4
    } sync_state_t;

    localparam int GLITCH_BITS = 8;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchroniser for a single asynchronous input.
// Reset clears the whole chain.
module cdc_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sync_receive.sv
// Receive side of the board-to-board sync: glitch-filtered edge
// acceptance, programmable trigger delay and arm-to-edge measurement.
module sync_receive
    import sync_receive_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int PULSE_LENGTH = 2,
    parameter int DELAY_BITS   = 10,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    sync_in,
    input  logic                    arm,
    input  logic [DELAY_BITS-1:0]   delay,
    input  logic [TIMEOUT_BITS-1:0] timeout,
    output logic                    trigger,
    output logic                    waiting,
    output logic                    done,
    output logic                    timeout_err,
    output logic [GLITCH_BITS-1:0]  glitch_count,
    output logic [TIMEOUT_BITS-1:0] wait_cycles
);

    localparam int WIDTH_BITS = clogb2(PULSE_LENGTH + 1);
    localparam logic [TIMEOUT_BITS-1:0] T_ONE = TIMEOUT_BITS'(1);
    localparam logic [DELAY_BITS-1:0]   D_ONE = DELAY_BITS'(1);
    localparam logic [WIDTH_BITS-1:0]   W_ONE = WIDTH_BITS'(1);
    localparam logic [WIDTH_BITS-1:0]   W_LAST =
        WIDTH_BITS'(PULSE_LENGTH - 1);

    sync_state_t state_q, state_d;

    logic                    s, s_prev, sync_rise, arm_q;
    logic [DELAY_BITS-1:0]   delay_q, dcnt;
    logic [TIMEOUT_BITS-1:0] timeout_q, wait_cnt;
    logic [WIDTH_BITS-1:0]   width_q;
    logic                    start, accept, glitch, expire, fire;

    cdc_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (sync_in),
        .q       (s)
    );

    assign sync_rise = s & ~s_prev;
    assign waiting   = (state_q == ST_WAIT) || (state_q == ST_CHECK);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        accept  = 1'b0;
        glitch  = 1'b0;
        expire  = 1'b0;
        fire    = 1'b0;
        if (!arm) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!arm_q) begin
                        start   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // an edge in the same cycle beats the timeout
                    if (sync_rise) begin
                        if (PULSE_LENGTH == 1) begin
                            accept  = 1'b1;
                            state_d = ST_DELAY;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end else if (timeout_q != '0 &&
                                 wait_cnt == timeout_q - T_ONE) begin
                        expire  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_CHECK: begin
                    if (!s) begin
                        glitch  = 1'b1;
                        state_d = ST_WAIT;
                    end else if (width_q == W_LAST) begin
                        accept  = 1'b1;
                        state_d = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (dcnt == '0) begin
                        fire    = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            s_prev       <= 1'b0;
            arm_q        <= 1'b0;
            delay_q      <= '0;
            timeout_q    <= '0;
            wait_cnt     <= '0;
            width_q      <= '0;
            dcnt         <= '0;
            trigger      <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            glitch_count <= '0;
            wait_cycles  <= '0;
        end else begin
            state_q <= state_d;
            s_prev  <= s;
            arm_q   <= arm;
            trigger <= fire;
            if (start) begin
                delay_q      <= delay;
                timeout_q    <= timeout;
                wait_cnt     <= '0;
                glitch_count <= '0;
                wait_cycles  <= '0;
                timeout_err  <= 1'b0;
                done         <= 1'b0;
            end else if (waiting && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + T_ONE;
            end
            if (state_q == ST_WAIT && sync_rise) begin
                width_q <= W_ONE;
            end else if (state_q == ST_CHECK && s) begin
                width_q <= width_q + W_ONE;
            end
            if (glitch && glitch_count != '1) begin
                glitch_count <= glitch_count + 8'd1;
            end
            if (accept) begin
                wait_cycles <= wait_cnt;
                dcnt        <= delay_q;
            end else if (state_q == ST_DELAY && dcnt != '0) begin
                dcnt <= dcnt - D_ONE;
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end
            if (expire || fire) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_receive.sv
// Randomised scoreboard bench for sync_receive with an event-level
// reference model of pulse acceptance, delay and timeout.
module tb_sync_receive;

    localparam int SYNC_STAGES  = 2;
    localparam int PULSE_LENGTH = 2;
    localparam int DELAY_BITS   = 10;
    localparam int TIMEOUT_BITS = 16;

    typedef struct {
        int trig_edge;
        int trig_cnt;
        int tmo;
        int glitches;
        int wc;
    } exp_t;

    logic                    clock, reset_n, sync_in, arm;
    logic [DELAY_BITS-1:0]   delay;
    logic [TIMEOUT_BITS-1:0] timeout;
    logic                    trigger, waiting, done, timeout_err;
    logic [7:0]              glitch_count;
    logic [TIMEOUT_BITS-1:0] wait_cycles;

    int   cyc;
    int   n_checks, n_fail;
    int   trig_seen, last_trig;
    logic trig_q, done_q;
    exp_t expq[$];

    int   npulse;
    int   pgap[4];
    int   plen[4];
    int   pstart[4];

    sync_receive #(
        .SYNC_STAGES  (SYNC_STAGES),
        .PULSE_LENGTH (PULSE_LENGTH),
        .DELAY_BITS   (DELAY_BITS),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sync_in      (sync_in),
        .arm          (arm),
        .delay        (delay),
        .timeout      (timeout),
        .trigger      (trigger),
        .waiting      (waiting),
        .done         (done),
        .timeout_err  (timeout_err),
        .glitch_count (glitch_count),
        .wait_cycles  (wait_cycles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Edge numbers: cycle 0 of a pulse is the edge where the first
    // synchroniser flop captures 1; the synchronised edge is acted on
    // SYNC_STAGES edges later.
    function automatic exp_t model(input int a, input int dly,
                                   input int tmo);
        exp_t e;
        e.trig_edge = -1;
        e.trig_cnt  = 0;
        e.tmo       = 0;
        e.glitches  = 0;
        e.wc        = 0;
        for (int i = 0; i < npulse; i++) begin
            int det;
            int acc;
            det = pstart[i] + SYNC_STAGES;
            if (tmo != 0 && det > a + tmo) break;
            if (plen[i] >= PULSE_LENGTH) begin
                acc = det + PULSE_LENGTH - 1;
                e.trig_edge = acc + 1 + dly;
                e.trig_cnt  = 1;
                e.wc        = acc - a - 1;
                return e;
            end
            e.glitches++;
        end
        if (tmo != 0) e.tmo = 1;
        return e;
    endfunction

    initial begin
        exp_t e;
        trig_q    = 1'b0;
        done_q    = 1'b0;
        trig_seen = 0;
        last_trig = -1;
        forever begin
            @(negedge clock);
            if (trigger) begin
                chk("trigger_single_cycle", int'(trig_q), 0);
                trig_seen++;
                last_trig = cyc;
            end
            trig_q = trigger;
            if (done && !done_q) begin
                chk("done_expected", expq.size(), 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("trigger_edge", last_trig, e.trig_edge);
                    chk("trigger_count", trig_seen, e.trig_cnt);
                    chk("timeout_err", int'(timeout_err), e.tmo);
                    chk("glitch_count", int'(glitch_count), e.glitches);
                    chk("wait_cycles", int'(wait_cycles), e.wc);
                end
                trig_seen = 0;
                last_trig = -1;
            end
            done_q = done;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        step();
        while (!done && n < 3000) begin
            step();
            n++;
        end
        chk("done_reached", int'(done), 1);
    endtask

    task automatic release_arm();
        arm = 1'b0;
        step();
        step();
    endtask

    task automatic run_case(input int dly, input int tmo);
        int cur;
        cur = cyc;
        for (int i = 0; i < npulse; i++) begin
            cur += pgap[i];
            pstart[i] = cur + 1;
            cur += plen[i];
        end
        expq.push_back(model(cyc + 1, dly, tmo));
        delay   = DELAY_BITS'(dly);
        timeout = TIMEOUT_BITS'(tmo);
        arm     = 1'b1;
        for (int i = 0; i < npulse; i++) begin
            repeat (pgap[i]) step();
            sync_in = 1'b1;
            repeat (plen[i]) step();
            sync_in = 1'b0;
        end
        wait_done();
        release_arm();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_trigger"}, int'(trigger), 0);
        chk({tag, "_waiting"}, int'(waiting), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_timeout_err"}, int'(timeout_err), 0);
        chk({tag, "_glitch_count"}, int'(glitch_count), 0);
        chk({tag, "_wait_cycles"}, int'(wait_cycles), 0);
    endtask

    initial begin
        exp_t e;
        int   a, p, snap, ng;
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        sync_in  = 1'b0;
        arm      = 1'b0;
        delay    = '0;
        timeout  = '0;
        repeat (3) step();
        check_zero("reset");
        #1 reset_n = 1'b1;
        repeat (2) step();

        // basic accept, delay 3
        npulse = 1; pgap[0] = 2; plen[0] = 5;
        run_case(3, 0);

        // one glitch then a valid pulse
        npulse = 2; pgap[0] = 3; plen[0] = 1; pgap[1] = 20; plen[1] = 4;
        run_case(3, 0);

        // timeout with no pulse, then readback after disarm
        npulse = 0;
        run_case(5, 50);
        chk("hold_timeout_err", int'(timeout_err), 1);
        chk("hold_done", int'(done), 1);

        // edge acted on in the last WAIT cycle beats the timeout
        npulse = 1; pgap[0] = 48; plen[0] = 4;
        run_case(2, 50);

        // edge one cycle too late: timeout wins
        npulse = 1; pgap[0] = 49; plen[0] = 4;
        run_case(2, 50);

        // long wait, delay 0
        npulse = 1; pgap[0] = 100; plen[0] = 3;
        run_case(0, 0);

        // disarm during a long delay cancels the trigger
        npulse = 1; pgap[0] = 2; plen[0] = 4;
        pstart[0] = cyc + 3;
        a = cyc + 1;
        e = model(a, 500, 0);
        delay = 10'd500; timeout = '0; arm = 1'b1;
        repeat (2) step();
        sync_in = 1'b1;
        repeat (4) step();
        sync_in = 1'b0;
        repeat (10) step();
        snap = trig_seen;
        arm = 1'b0;
        step();
        chk("abort_waiting", int'(waiting), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_wait_cycles", int'(wait_cycles), e.wc);
        repeat (520) step();
        chk("abort_no_trigger", trig_seen, snap);

        npulse = 1; pgap[0] = 4; plen[0] = 2;
        run_case(2, 0);

        // async reset in the middle of CHECK
        delay = 10'd2; timeout = '0; arm = 1'b1;
        repeat (3) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        repeat (6) step();
        sync_in = 1'b1;
        p = cyc + 1;
        while (cyc < p + SYNC_STAGES) step();
        chk("pre_reset_glitches", int'(glitch_count), 1);
        chk("pre_reset_waiting", int'(waiting), 1);
        snap = trig_seen;
        #1 reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        sync_in = 1'b0;
        arm = 1'b0;
        #1 reset_n = 1'b1;
        step();
        sync_in = 1'b1;
        repeat (4) step();
        sync_in = 1'b0;
        repeat (10) step();
        chk("no_arm_trigger", trig_seen, snap);
        chk("no_arm_done", int'(done), 0);

        npulse = 1; pgap[0] = 3; plen[0] = 4;
        run_case(1, 0);

        // randomised cases
        for (int k = 0; k < 12; k++) begin
            ng = int'($urandom_range(0, 2));
            npulse = ng + 1;
            for (int i = 0; i < ng; i++) begin
                pgap[i] = int'($urandom_range(3, 10));
                plen[i] = int'($urandom_range(1, PULSE_LENGTH - 1));
            end
            pgap[0]  = int'($urandom_range(1, 10));
            pgap[ng] = (ng == 0) ? pgap[0] : int'($urandom_range(3, 10));
            plen[ng] = int'($urandom_range(PULSE_LENGTH, 6));
            run_case(int'($urandom_range(0, 15)),
                     ($urandom_range(0, 1) == 0) ? 0 :
                     int'($urandom_range(200, 400)));
        end

        repeat (3) step();
        chk("queue_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_receive.md
Name: sync_receive

Overview:
- Receive-side counterpart of the board-to-board sync pulse generator.
- Samples the asynchronous sync line from the primary board and rejects glitches shorter than the pulse length.
- After a programmable delay, issues a single-cycle start trigger to the local timing core.
- Measures the wait from arm to accepted edge, for cable/latency calibration.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on sync_in (>=2).
- PULSE_LENGTH, 2: minimum accepted high time of the synchronised sync, in clock cycles (>=1).
- DELAY_BITS, 10: width of the delay input.
- TIMEOUT_BITS, 16: width of the timeout input and the wait counter.

Ports:
- clock, in, 1: single system clock.
- reset_n, in, 1: asynchronous active-low reset.
- sync_in, in, 1: asynchronous sync line from the primary board.
- arm, in, 1: level. 1 = armed; 0 = return to idle.
- delay, in, DELAY_BITS: cycles between acceptance and trigger. Sampled on the arm rising edge.
- timeout, in, TIMEOUT_BITS: maximum wait cycles; 0 = wait forever. Sampled on the arm rising edge.
- trigger, out, 1: one-cycle start pulse.
- waiting, out, 1: high in WAIT and CHECK states.
- done, out, 1: high in DONE state.
- timeout_err, out, 1: sticky; cleared on the next arm rising edge.
- glitch_count, out, 8: saturating count of rejected pulses since arm.
- wait_cycles, out, TIMEOUT_BITS: WAIT/CHECK cycles counted from the arm edge, captured at acceptance.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0, all counters 0, synchroniser flops 0.
- Synchroniser:
  - s = output of the SYNC_STAGES-deep chain; s_prev is s delayed one cycle.
  - Edge = s & ~s_prev.
- IDLE:
  - Outputs hold their last values.
  - On arm=1: latch delay and timeout; clear wait counter, glitch_count, wait_cycles and timeout_err; go to WAIT.
- WAIT:
  - Wait counter increments each cycle and saturates at all-ones.
  - On edge: go to CHECK with width=1. If PULSE_LENGTH=1, accept immediately instead (see Accept).
  - If timeout!=0 and wait counter == timeout-1 with no edge: set timeout_err and go to DONE.
  - Edge wins over timeout in the same cycle.
- CHECK:
  - Wait counter keeps running; the timeout is not evaluated here.
  - If s=1: width++. When width reaches PULSE_LENGTH, accept.
  - If s=0 before that: glitch_count++ (saturates at 255) and return to WAIT.
- Accept:
  - wait_cycles <= wait counter.
  - Load the delay down-counter with the latched delay and go to DELAY.
- DELAY:
  - Counts down to 0. When 0, trigger=1 for exactly one cycle and go to DONE.
  - delay=0 gives the trigger in the cycle after acceptance.
  - Latency requirement: trigger is high at cycle SYNC_STAGES+PULSE_LENGTH+delay. Cycle 0 is the first clock edge at which the first synchroniser flop captures 1.
- DONE:
  - done=1; stays until arm=0, then goes to IDLE.
  - Further sync pulses are ignored.
- arm=0 in any state:
  - Next state is IDLE; any pending trigger is cancelled and trigger is never asserted.
  - done, timeout_err, glitch_count and wait_cycles hold their values for readback.
- Re-arm is only possible via IDLE; arm must be low for at least 1 cycle.
- sync_in already high when arm rises: no edge is seen, so the block waits for the next low-to-high transition.

Decomposition:
- Shared package/header: state encoding constants (IDLE, WAIT, CHECK, DELAY, DONE) and the clogb2 function, shared with the sync pulse generator.
- Sub-module cdc_sync: parameterised SYNC_STAGES flop chain with async active-low reset. Reusable for the other async inputs.

Test Plan:
- Defaults, delay=3, timeout=0; arm, then sync_in high for 5 cycles -> trigger high exactly at cycle 7, single cycle; done=1; glitch_count=0.
- sync_in high 1 cycle, then a valid 4-cycle pulse 20 cycles later -> glitch_count=1; trigger at cycle 7 relative to the second pulse; no trigger from the first.
- timeout=50 with no sync pulse -> timeout_err=1 and done=1 after 50 cycles in WAIT; trigger never asserted. Edge arriving exactly at cycle 49 -> accepted, timeout_err=0.
- delay=0, pulse arrives 100 cycles after arm -> trigger at cycle 4; wait_cycles within 100+SYNC_STAGES+1 ±1 (checked against the model).
- arm dropped during DELAY (delay=500) -> no trigger; state IDLE next cycle. Re-arm with a new pulse -> normal trigger.
- reset_n asserted asynchronously mid-CHECK -> all outputs 0 immediately. After release, requires a fresh arm before any trigger.
